sprite_motion_ctrl: RTL

//  - Frame-rate motion engine feeding tile_layer's i_offset_x / i_offset_y in top.
//  - Counts vertical-sync pulses from vga_controller; every FRAME_DIV frames it applies velocity to the position.
//  - Bounces off the [0, X_MAX) x [0, Y_MAX) bounds.
//  - Runs in the pixel-clock domain; replaces the ad-hoc posedge-vsync logic.

---
 rtl/sprite_motion_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
//
// Frame-rate motion engine for the scrolling tile layer. It counts vertical-sync
// pulses in the pixel-clock domain and, every FRAME_DIV frames, spends one
// cycle (STEP) adding the velocity to the position. Each axis independently
// reflects off the [0, MAX) bounds.
//
// Optional feature: define SPRITE_MOTION_WRAP_EN to get toroidal wrap instead
// of bouncing. In that build velocities never change and the bounce pulses
// stay at 0.
//
// Ports
//   i_pix_clk    in   1   pixel clock, sole clock
//   i_reset      in   1   synchronous active-high reset
//   i_vert_sync  in   1   vertical sync (active level SYNC_POL), same domain
//   i_enable     in   1   1 = count frames and move, 0 = freeze
//   o_offset_x   out  16  signed x position
//   o_offset_y   out  16  signed y position
//   o_vel_x      out  16  signed x velocity
//   o_vel_y      out  16  signed y velocity
//   o_update     out  1   one-cycle pulse, offsets changed this cycle
//   o_bounce_x   out  1   one-cycle pulse with o_update, x reflected
//   o_bounce_y   out  1   one-cycle pulse with o_update, y reflected
// -----------------------------------------------------------------------------
module sprite_motion_ctrl #(
    parameter int X_MAX     = 800,
    parameter int Y_MAX     = 150,
    parameter int FRAME_DIV = 8,
    parameter int INIT_VX   = 2,
    parameter int INIT_VY   = 0,
    parameter bit SYNC_POL  = 1'b1
) (
    input  logic               i_pix_clk,
    input  logic               i_reset,
    input  logic               i_vert_sync,
    input  logic               i_enable,
    output logic signed [15:0] o_offset_x,
    output logic signed [15:0] o_offset_y,
    output logic signed [15:0] o_vel_x,
    output logic signed [15:0] o_vel_y,
    output logic               o_update,
    output logic               o_bounce_x,
    output logic               o_bounce_y
);

    // FRAME_DIV == 1 would give a zero-width counter; keep at least one bit.
    localparam int              CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    typedef enum logic {
        ST_IDLE,
        ST_STEP
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;
    logic              sync_q_reg;
    logic [1:0][15:0]  off_reg, off_next, vel_reg, vel_next;
    logic [1:0][15:0]  off_step, vel_step;
    logic [1:0]        bounce_reg, bounce_next, bounce_step;
    logic              update_reg, update_next;
    logic              frame_edge;

    // Leading edge of the active sync level.
    assign frame_edge = (i_vert_sync == SYNC_POL) && (sync_q_reg != SYNC_POL);

    // Per-axis candidate result of a step; index 0 = x, 1 = y.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam int               LIM   = (gi == 0) ? X_MAX : Y_MAX;
            localparam logic signed [16:0] LIM_S = 17'(LIM);

            logic signed [16:0] sum;
            logic [15:0]        off_c;
            logic [15:0]        vel_c;
            logic               bnc_c;

            // 17-bit signed sum so overflow past 16 bits never aliases into range.
            assign sum = $signed({off_reg[gi][15], off_reg[gi]})
                       + $signed({vel_reg[gi][15], vel_reg[gi]});

`ifdef SPRITE_MOTION_WRAP_EN
            localparam logic [15:0] LIM_16 = 16'(LIM);

            always_comb begin
                off_c = sum[15:0];
                vel_c = vel_reg[gi];
                bnc_c = 1'b0;
                if (sum >= LIM_S) begin
                    off_c = sum[15:0] - LIM_16;
                end else if (sum[16]) begin
                    off_c = sum[15:0] + LIM_16;
                end
            end
`else
            localparam logic [15:0] LIM_M1 = 16'(LIM - 1);

            always_comb begin
                off_c = sum[15:0];
                vel_c = vel_reg[gi];
                bnc_c = 1'b0;
                if (sum >= LIM_S) begin
                    off_c = LIM_M1;
                    vel_c = ~vel_reg[gi] + 16'd1;
                    bnc_c = 1'b1;
                end else if (sum[16]) begin
                    off_c = 16'd0;
                    vel_c = ~vel_reg[gi] + 16'd1;
                    bnc_c = 1'b1;
                end
            end
`endif

            assign off_step[gi]    = off_c;
            assign vel_step[gi]    = vel_c;
            assign bounce_step[gi] = bnc_c;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        off_next       = off_reg;
        vel_next       = vel_reg;
        bounce_next    = 2'b00;
        update_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (frame_edge && i_enable) begin
                    if (frame_cnt_reg == CNT_LAST) begin
                        frame_cnt_next = '0;
                        state_next     = ST_STEP;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_STEP: begin
                // Commits regardless of i_enable: a started step always finishes.
                // An edge cannot be seen here (sync was active last cycle).
                off_next    = off_step;
                vel_next    = vel_step;
                bounce_next = bounce_step;
                update_next = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            state_reg     <= ST_IDLE;
            frame_cnt_reg <= '0;
            sync_q_reg    <= ~SYNC_POL;
            off_reg       <= '0;
            vel_reg[0]    <= 16'(INIT_VX);
            vel_reg[1]    <= 16'(INIT_VY);
            bounce_reg    <= 2'b00;
            update_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            frame_cnt_reg <= frame_cnt_next;
            sync_q_reg    <= i_vert_sync;
            off_reg       <= off_next;
            vel_reg       <= vel_next;
            bounce_reg    <= bounce_next;
            update_reg    <= update_next;
        end
    end

    assign o_offset_x = $signed(off_reg[0]);
    assign o_offset_y = $signed(off_reg[1]);
    assign o_vel_x    = $signed(vel_reg[0]);
    assign o_vel_y    = $signed(vel_reg[1]);
    assign o_update   = update_reg;
    assign o_bounce_x = bounce_reg[0];
    assign o_bounce_y = bounce_reg[1];

endmodule
